u_d_slew_driver: RTL and testbench
==================================

Name: u_d_slew_driver

Overview:
- Command-side counterpart of the feedback up/down binary counter.
- Accepts a target code over a valid/ready handshake and emits a registered `u_d`/`en` command stream. A counter driven by that stream walks one LSB per clock from its current value to the target, then stops.
- Keeps an internal mirror of the remote counter, including its reset value of midscale (`1000..0`), so the mirror and the counter stay in lockstep.
- Sits in the feedback path between the digital loop controller and the counter.

Parameters:
- `WIDTH`, 16, counter/target width in bits.
- `SETTLE_CYC`, 4, idle cycles held after reaching target before `done` pulses; legal range 0..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rstb` input 1: reset, asynchronous, active-low.
- `tgt_valid` input 1: target offered.
- `tgt` input WIDTH: target code, unsigned offset-binary.
- `tgt_ready` output 1: block can accept a target.
- `hold` input 1: freeze slewing while high.
- `u_d` output 1: direction to counter; 1 = increment, 0 = decrement.
- `en` output 1: counter enable; one LSB step per clock while high.
- `mirror` output WIDTH: modelled remote counter value.
- `busy` output 1: a target is in progress (states SLEW or SETTLE).
- `done` output 1: one-cycle pulse when a target completes.

Behaviour:
- Reset values (while `rstb` = 0):
  - State = IDLE, `mirror` = 2^(WIDTH-1).
  - `en`, `u_d`, `busy`, `done` = 0; `tgt_ready` = 1.
  - Reset mid-operation discards the target and the settle count immediately.
- All outputs are registered. `tgt_ready` = (state == IDLE).
- Mirror update, every edge:
  - If `en` = 1: `mirror` <= `mirror` + 1 when `u_d` = 1, else `mirror` - 1.
  - If `en` = 0: `mirror` holds.
  - This matches the counter sampling the same registered `en`/`u_d`.
- Definition: `nm` = the value of `mirror` after the current edge.
- Next-state `en` = (state' == SLEW) && !`hold` && (`nm` != `tgt_r`).
- Next-state `u_d` = (`tgt_r` > `nm`). When `en` is low, `u_d` holds its last value.
- Result: `en` is high for exactly |`tgt` - start mirror| cycles, excluding hold cycles. There is never overshoot or wrap, since `mirror` only moves toward `tgt_r` inside [0, 2^WIDTH-1].
- IDLE:
  - On `tgt_valid` && `tgt_ready`, latch `tgt_r` = `tgt`.
  - If `tgt` != `mirror`: go to SLEW; `en`/`u_d` are valid on the same edge (first step counted at the next edge).
  - If `tgt` == `mirror`: go to SETTLE directly.
- SLEW:
  - Stays while steps remain.
  - Moves to SETTLE on the edge where `nm` == `tgt_r`; `en` falls on that edge.
  - `hold` = 1 forces `en` = 0 from the next edge; the state is kept and slewing resumes when `hold` falls.
- SETTLE:
  - Counter loaded with `SETTLE_CYC`; decrements each cycle.
  - When the counter is 0, go to IDLE with `done` = 1 for one cycle.
  - `SETTLE_CYC` = 0 gives `done` on the edge after entering SETTLE.
  - `hold` does not affect SETTLE.
- `tgt_valid` outside IDLE is ignored. The target is not queued, and `tgt` changes after acceptance have no effect.
- A target can be accepted in the same cycle that `done` is high (IDLE with `done` asserted).

Test Plan:
1. Reset, `SETTLE_CYC` = 2 -> `mirror` = 0x8000, `en` = 0, `tgt_ready` = 1. Offer `tgt` = 0x8005 -> `en` high exactly 5 cycles with `u_d` = 1, `mirror` = 0x8005, then 2 settle cycles, then one `done` pulse, then `tgt_ready` = 1.
2. From 0x8005, `tgt` = 0x7FFE -> 7 cycles of `en` with `u_d` = 0, final `mirror` = 0x7FFE. Verify lockstep against an instantiated up/down counter on every cycle.
3. `tgt` equal to `mirror` (0x7FFE) -> `en` never asserts, `busy` high for the settle period, one `done` pulse.
4. `tgt` = 0x8010 from 0x8000; assert `hold` for 3 cycles after 4 steps -> `en` low 3 cycles, `mirror` frozen at 0x8004, resumes; 16 total enabled cycles.
5. `tgt_valid` pulsed with 0x0000 mid-slew -> ignored, original target reached. Assert `rstb` = 0 mid-slew -> `mirror` = 0x8000 and `en` = 0 immediately, `done` not pulsed.
6. `WIDTH` = 4: from 0x8 drive `tgt` = 0xF then 0x0 -> 7 up steps then 15 down steps, no wrap at bounds.

Source files
------------

// File: rtl/u_d_slew_driver.sv
// Command-side slew driver: walks a remote up/down counter one LSB per clock
// toward an accepted target while keeping a lockstep mirror of that counter.
module u_d_slew_driver #(
  parameter int WIDTH      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt,
  output logic             tgt_ready,
  input  logic             hold,
  output logic             u_d,
  output logic             en,
  output logic [WIDTH-1:0] mirror,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLEW   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MID_CODE    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_LSB     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] w_tgt_nxt;
  logic [7:0]       r_settle;
  logic [7:0]       w_settle_nxt;
  logic [WIDTH-1:0] w_nm;
  logic             w_en_nxt;
  logic             w_u_d_nxt;
  logic             w_done_nxt;

  // Mirror value after this edge: the remote counter samples the same en/u_d.
  assign w_nm = en ? (u_d ? (mirror + ONE_LSB) : (mirror - ONE_LSB)) : mirror;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= ST_IDLE;
      r_tgt     <= MID_CODE;
      r_settle  <= 8'd0;
      mirror    <= MID_CODE;
      en        <= 1'b0;
      u_d       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_ready <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tgt     <= w_tgt_nxt;
      r_settle  <= w_settle_nxt;
      mirror    <= w_nm;
      en        <= w_en_nxt;
      u_d       <= w_u_d_nxt;
      busy      <= (w_state_nxt != ST_IDLE);
      done      <= w_done_nxt;
      tgt_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tgt_nxt    = r_tgt;
    w_settle_nxt = r_settle;
    case (r_state)
      ST_IDLE: begin
        if (tgt_valid && tgt_ready) begin
          w_tgt_nxt = tgt;
          if (tgt != w_nm) begin
            w_state_nxt = ST_SLEW;
          end else begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = SETTLE_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SLEW: begin
        if (w_nm == r_tgt) begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = SETTLE_LOAD;
        end else begin
          w_state_nxt = ST_SLEW;
        end
      end
      ST_SETTLE: begin
        if (r_settle == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_settle_nxt = r_settle - 8'd1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_settle_nxt = 8'd0;
      end
    endcase
  end

  // Direction only updates on stepping cycles so u_d is stable while idle/held.
  always_comb begin
    w_en_nxt   = (w_state_nxt == ST_SLEW) && !hold && (w_nm != w_tgt_nxt);
    w_done_nxt = (r_state == ST_SETTLE) && (r_settle == 8'd0);
    if (w_en_nxt) begin
      w_u_d_nxt = (w_tgt_nxt > w_nm);
    end else begin
      w_u_d_nxt = u_d;
    end
  end

endmodule

// File: tb/tb_u_d_slew_driver.sv
// Scoreboard bench for u_d_slew_driver: a 16-bit and a 4-bit instance, each
// tracked against a behavioural remote up/down counter every cycle.
module tb_u_d_slew_driver;

  typedef struct {
    int   steps;
    int   fin;
    int   busy;
    logic dir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic        tgt_valid16, tgt_valid4;
  logic [15:0] tgt16;
  logic [3:0]  tgt4;
  logic        hold16, hold4;
  logic        tgt_ready16, tgt_ready4;
  logic        ud16, ud4, en16, en4;
  logic [15:0] mirror16;
  logic [3:0]  mirror4;
  logic        busy16, busy4, done16, done4;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int   ref_m[2];
  int   mid_v[2];
  int   settle_v[2];
  logic prev_en[2];
  logic prev_ud[2];
  int   en_cnt[2];
  int   busy_cnt[2];
  logic last_done[2];

  always #5 clk = ~clk;

  u_d_slew_driver #(.WIDTH(16), .SETTLE_CYC(2)) dut16 (
    .clk(clk), .rstb(rstb), .tgt_valid(tgt_valid16), .tgt(tgt16),
    .tgt_ready(tgt_ready16), .hold(hold16), .u_d(ud16), .en(en16),
    .mirror(mirror16), .busy(busy16), .done(done16)
  );

  u_d_slew_driver #(.WIDTH(4), .SETTLE_CYC(0)) dut4 (
    .clk(clk), .rstb(rstb), .tgt_valid(tgt_valid4), .tgt(tgt4),
    .tgt_ready(tgt_ready4), .hold(hold4), .u_d(ud4), .en(en4),
    .mirror(mirror4), .busy(busy4), .done(done4)
  );

  task automatic check_val(input string tag, input int obs, input int expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Per-cycle monitor for one instance: remote-counter lockstep and scoreboard pops.
  task automatic mon(input int d, input logic e, input logic ud, input int mir,
                     input logic b, input logic dn);
    exp_t x;
    last_done[d] = dn;
    if (!rstb) begin
      ref_m[d]    = mid_v[d];
      prev_en[d]  = 1'b0;
      prev_ud[d]  = 1'b0;
      en_cnt[d]   = 0;
      busy_cnt[d] = 0;
    end else begin
      if (prev_en[d]) ref_m[d] = prev_ud[d] ? ref_m[d] + 1 : ref_m[d] - 1;
      check_val($sformatf("lockstep%0d", d), mir, ref_m[d]);
      if (e) begin
        en_cnt[d]++;
        if (d == 0 && sb0.size() > 0) check_val("dir16", int'(ud), int'(sb0[0].dir));
        else if (d == 1 && sb1.size() > 0) check_val("dir4", int'(ud), int'(sb1[0].dir));
        else check_val($sformatf("en_no_target%0d", d), int'(e), 0);
      end
      if (b) busy_cnt[d]++;
      if (dn) begin
        if (d == 0 && sb0.size() > 0) begin
          x = sb0.pop_front();
        end else if (d == 1 && sb1.size() > 0) begin
          x = sb1.pop_front();
        end else begin
          check_val($sformatf("spurious_done%0d", d), int'(dn), 0);
          x.steps = en_cnt[d]; x.fin = mir; x.busy = busy_cnt[d]; x.dir = 1'b0;
        end
        check_val($sformatf("steps%0d", d), en_cnt[d], x.steps);
        check_val($sformatf("final%0d", d), mir, x.fin);
        check_val($sformatf("busy_len%0d", d), busy_cnt[d], x.busy);
        en_cnt[d]   = 0;
        busy_cnt[d] = 0;
      end
      prev_en[d] = e;
      prev_ud[d] = ud;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon(0, en16, ud16, int'(mirror16), busy16, done16);
    mon(1, en4, ud4, int'(mirror4), busy4, done4);
  endtask

  task automatic offer(input int d, input int t, input int holds);
    exp_t x;
    int   diff;
    diff    = t - ref_m[d];
    x.steps = (diff < 0) ? -diff : diff;
    x.fin   = t;
    x.busy  = x.steps + holds + settle_v[d] + 1;
    x.dir   = (diff > 0);
    if (d == 0) begin
      check_val("ready16", int'(tgt_ready16), 1);
      sb0.push_back(x);
      tgt16 = 16'(t);
      tgt_valid16 = 1'b1;
    end else begin
      check_val("ready4", int'(tgt_ready4), 1);
      sb1.push_back(x);
      tgt4 = 4'(t);
      tgt_valid4 = 1'b1;
    end
    tick();
    tgt_valid16 = 1'b0;
    tgt_valid4  = 1'b0;
  endtask

  task automatic wait_done(input int d, input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      seen = last_done[d];
    end
    check_val($sformatf("done_seen%0d", d), int'(seen), 1);
  endtask

  initial begin
    mid_v[0] = 32'h8000; mid_v[1] = 8;
    settle_v[0] = 2;     settle_v[1] = 0;
    for (int i = 0; i < 2; i++) begin
      ref_m[i] = mid_v[i]; prev_en[i] = 1'b0; prev_ud[i] = 1'b0;
      en_cnt[i] = 0; busy_cnt[i] = 0; last_done[i] = 1'b0;
    end
    rstb = 1'b0;
    tgt_valid16 = 1'b0; tgt_valid4 = 1'b0;
    tgt16 = 16'h0000; tgt4 = 4'h0;
    hold16 = 1'b0; hold4 = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
    tick();
    check_val("rst_mirror16", int'(mirror16), 32'h8000);
    check_val("rst_en16", int'(en16), 0);
    check_val("rst_ud16", int'(ud16), 0);
    check_val("rst_busy16", int'(busy16), 0);
    check_val("rst_done16", int'(done16), 0);
    check_val("rst_ready16", int'(tgt_ready16), 1);
    check_val("rst_mirror4", int'(mirror4), 8);

    // Up by 5, down by 7, then a zero-length target
    offer(0, 32'h8005, 0);
    wait_done(0, 100);
    check_val("ready_after_done", int'(tgt_ready16), 1);
    offer(0, 32'h7FFE, 0);
    wait_done(0, 100);
    offer(0, 32'h7FFE, 0);
    check_val("eq_busy", int'(busy16), 1);
    wait_done(0, 100);

    // Back to midscale, then a 16-step slew with a 3-cycle hold after 4 steps
    offer(0, 32'h8000, 0);
    wait_done(0, 100);
    offer(0, 32'h8010, 3);
    for (int i = 0; i < 3; i++) tick();
    hold16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("hold_en", int'(en16), 0);
      check_val("hold_mirror", int'(mirror16), 32'h8004);
    end
    hold16 = 1'b0;
    wait_done(0, 100);

    // A new offer mid-slew is ignored
    offer(0, 32'h8008, 0);
    tick();
    check_val("busy_ready", int'(tgt_ready16), 0);
    tgt16 = 16'h0000;
    tgt_valid16 = 1'b1;
    tick();
    tgt_valid16 = 1'b0;
    wait_done(0, 100);
    check_val("ignored_final", int'(mirror16), 32'h8008);

    // Reset mid-slew clears everything at once and no done follows
    offer(0, 32'h8020, 0);
    for (int i = 0; i < 4; i++) tick();
    rstb = 1'b0;
    #1;
    check_val("arst_mirror", int'(mirror16), 32'h8000);
    check_val("arst_en", int'(en16), 0);
    check_val("arst_busy", int'(busy16), 0);
    check_val("arst_ready", int'(tgt_ready16), 1);
    sb0.delete();
    tick();
    tick();
    rstb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("no_done_after_rst", int'(done16), 0);
      check_val("idle_after_rst", int'(mirror16), 32'h8000);
    end

    // 4-bit instance runs to both rails without wrapping
    offer(1, 15, 0);
    wait_done(1, 100);
    check_val("top_rail4", int'(mirror4), 15);
    offer(1, 0, 0);
    wait_done(1, 100);
    check_val("bottom_rail4", int'(mirror4), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rail_hold4", int'(mirror4), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
